// File: rtl/pkt_rr_arbiter.sv
// pkt_rr_arbiter: per-input word FIFOs with whole-packet round-robin grant onto one output stream.
// Define PKT_RR_ARBITER_PKT_CNT_EN to add the per-input forwarded-packet counters on pkt_cnt.
module pkt_rr_arbiter #(
   parameter int DATA_WIDTH      = 64,
   parameter int CTRL_WIDTH      = DATA_WIDTH/8,
   parameter int NUM_INPUTS      = 8,
   parameter int FIFO_DEPTH_BITS = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
   input  logic [NUM_INPUTS*CTRL_WIDTH-1:0] in_ctrl,
   input  logic [NUM_INPUTS-1:0]            in_wr,
   output logic [NUM_INPUTS-1:0]            in_rdy,
   output logic [DATA_WIDTH-1:0]            out_data,
   output logic [CTRL_WIDTH-1:0]            out_ctrl,
   output logic                             out_wr,
   input  logic                             out_rdy,
   output logic [NUM_INPUTS-1:0]            overflow
`ifdef PKT_RR_ARBITER_PKT_CNT_EN
   ,
   output logic [NUM_INPUTS*32-1:0]         pkt_cnt
`endif
);
   localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
   localparam int IW    = $clog2(NUM_INPUTS);
   localparam int WW    = DATA_WIDTH + CTRL_WIDTH;
   localparam int PW    = FIFO_DEPTH_BITS;

   typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

   logic [WW-1:0]         mem_q [NUM_INPUTS][DEPTH];
   logic [PW-1:0]         wptr_q [NUM_INPUTS];
   logic [PW-1:0]         wptr_d [NUM_INPUTS];
   logic [PW-1:0]         rptr_q [NUM_INPUTS];
   logic [PW-1:0]         rptr_d [NUM_INPUTS];
   logic [PW:0]           cnt_q [NUM_INPUTS];
   logic [PW:0]           cnt_d [NUM_INPUTS];
   logic [NUM_INPUTS-1:0] full, empty, push, pop, overflow_q, overflow_d;
   logic                  rdy_en_q;
   state_t                state_q, state_d;
   logic [IW-1:0]         grant_q, grant_d, rr_ptr_q, rr_ptr_d, sel;
   logic                  found, rd, eop;
   logic [WW-1:0]         rd_word;
   logic [CTRL_WIDTH-1:0] rd_ctrl;
   logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
   logic [CTRL_WIDTH-1:0] out_ctrl_q, out_ctrl_d;
   logic                  out_wr_q;

   for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_flags
      assign full[i]  = cnt_q[i] == (PW+1)'(DEPTH);
      assign empty[i] = cnt_q[i] == '0;
   end

   assign rd      = state_q != IDLE && !empty[grant_q] && out_rdy;
   assign rd_word = mem_q[grant_q][rptr_q[grant_q]];
   assign rd_ctrl = rd_word[WW-1 -: CTRL_WIDTH];
   assign eop     = rd && state_q == PAYLOAD && rd_ctrl != '0;

   assign in_rdy   = {NUM_INPUTS{rdy_en_q}} & ~full;
   assign overflow = overflow_q;
   assign out_data = out_data_q;
   assign out_ctrl = out_ctrl_q;
   assign out_wr   = out_wr_q;

   // A pop frees a slot in the same cycle, so a push into a full FIFO is kept then.
   always_comb begin
      for (int i = 0; i < NUM_INPUTS; i++) begin
         pop[i]        = rd && grant_q == IW'(i);
         push[i]       = in_wr[i] && (!full[i] || pop[i]);
         overflow_d[i] = overflow_q[i] | (in_wr[i] & full[i] & ~pop[i]);
         wptr_d[i]     = wptr_q[i] + PW'(push[i]);
         rptr_d[i]     = rptr_q[i] + PW'(pop[i]);
         cnt_d[i]      = cnt_q[i] + (PW+1)'(push[i]) - (PW+1)'(pop[i]);
      end
   end

   always_comb begin
      int idx;
      idx   = 0;
      sel   = rr_ptr_q;
      found = 1'b0;
      for (int k = 0; k < NUM_INPUTS; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= NUM_INPUTS) idx -= NUM_INPUTS;
         if (!found && !empty[idx]) begin
            sel   = IW'(idx);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      rr_ptr_d   = rr_ptr_q;
      out_data_d = rd ? rd_word[DATA_WIDTH-1:0] : out_data_q;
      out_ctrl_d = rd ? rd_ctrl : out_ctrl_q;
      if (state_q == IDLE && found) begin
         state_d = HDR;
         grant_d = sel;
      end else if (rd && state_q == HDR && rd_ctrl == '0) begin
         state_d = PAYLOAD;
      end else if (eop) begin
         state_d  = IDLE;
         rr_ptr_d = grant_q == IW'(NUM_INPUTS-1) ? '0 : grant_q + IW'(1);
      end
   end

   always_ff @(posedge clk)
      for (int i = 0; i < NUM_INPUTS; i++)
         if (push[i]) mem_q[i][wptr_q[i]] <= {in_ctrl[i*CTRL_WIDTH +: CTRL_WIDTH], in_data[i*DATA_WIDTH +: DATA_WIDTH]};

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         rr_ptr_q   <= '0;
         rdy_en_q   <= 1'b0;
         overflow_q <= '0;
         out_data_q <= '0;
         out_ctrl_q <= '0;
         out_wr_q   <= 1'b0;
         wptr_q     <= '{default: '0};
         rptr_q     <= '{default: '0};
         cnt_q      <= '{default: '0};
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         rr_ptr_q   <= rr_ptr_d;
         rdy_en_q   <= 1'b1;
         overflow_q <= overflow_d;
         out_data_q <= out_data_d;
         out_ctrl_q <= out_ctrl_d;
         out_wr_q   <= rd;
         wptr_q     <= wptr_d;
         rptr_q     <= rptr_d;
         cnt_q      <= cnt_d;
      end

`ifdef PKT_RR_ARBITER_PKT_CNT_EN
   logic [31:0] pc_q [NUM_INPUTS];
   logic [31:0] pc_d [NUM_INPUTS];

   always_comb
      for (int i = 0; i < NUM_INPUTS; i++)
         pc_d[i] = pc_q[i] + 32'(eop && grant_q == IW'(i));

   always_ff @(posedge clk or negedge reset)
      if (!reset) pc_q <= '{default: '0};
      else pc_q <= pc_d;

   for (genvar g = 0; g < NUM_INPUTS; g++) begin : g_cnt
      assign pkt_cnt[g*32 +: 32] = pc_q[g];
   end
`endif
endmodule
